// File: rtl/inst_prefetch_queue_pkg.sv
// Shared definitions for the instruction prefetch queue.
// Contents: XLEN / ILEN widths, word-align mask, prefetch FSM state
// encoding, and the queue entry layout {pc, instr}.
package inst_prefetch_queue_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] WORD_MASK = 32'hFFFF_FFFC;

  // IDLE: no request; REQ: request whose data is kept;
  // DRAIN: request still outstanding but its data is discarded.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DRAIN = 2'd2
  } pf_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } pf_entry_t;

endpackage

// File: rtl/inst_fifo.sv
// Synchronous FIFO holding fetched {pc, instr} pairs.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   push, push_data write an entry at the tail
//   pop             remove the head entry
//   flush           empty the queue (wins over push and pop)
//   head, valid     head entry and non-empty flag (from state only)
//   count           current occupancy 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module inst_fifo
  import inst_prefetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  pf_entry_t     push_data,
  input  logic          pop,
  input  logic          flush,
  output pf_entry_t     head,
  output logic          valid,
  output logic [CW-1:0] count
);

  pf_entry_t     mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic          do_push, do_pop;

  assign do_pop  = pop & (count != '0) & ~flush;
  // A push into a full queue is accepted only if the head leaves the same cycle.
  assign do_push = push & ~flush & ((count != CW'(DEPTH)) | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  assign head  = mem[rd_ptr];
  assign valid = (count != '0);

endmodule

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch unit in front of the F/D pipeline register.
// Fetches sequential words over a req/ack handshake, buffers them with
// their PCs, and presents one instruction per cycle. An execute-stage
// redirect flushes the queue and discards any in-flight fetch.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   mem_req/mem_addr/mem_ack/mem_rdata  instruction memory handshake
//   redirect, redirect_pc          taken branch/jump and its target
//   stall                          F/D hold, blocks dequeue
//   valid_out, instr_out, pc_out, pc_plus4_out  head of queue (0 when empty)
// Optional macro PREFETCH_PERF_EN adds saturating counters
//   perf_empty_cycles and perf_discards.
// RESET_PC is expected to be word aligned.
module inst_prefetch_queue
  import inst_prefetch_queue_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic [ILEN-1:0] mem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic            valid_out,
  output logic [ILEN-1:0] instr_out,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus4_out
`ifdef PREFETCH_PERF_EN
  ,
  output logic [31:0]     perf_empty_cycles,
  output logic [31:0]     perf_discards
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  pf_state_e       state, state_n;
  logic [XLEN-1:0] fetch_pc, fetch_pc_n, addr_q, addr_n, tgt;
  logic [CW-1:0]   count, cnt_n;
  logic            xfer, push, pop, space;
  pf_entry_t       head;

  assign tgt     = redirect_pc & WORD_MASK;
  assign xfer    = mem_req & mem_ack;
  assign mem_req = (state != S_IDLE);
  assign mem_addr = addr_q;

  // Redirect beats both push and pop in the same cycle.
  assign pop  = valid_out & ~stall & ~redirect;
  assign push = (state == S_REQ) & xfer & ~redirect;

  // Space is judged on the occupancy after this cycle's push/pop/flush.
  assign cnt_n = redirect ? '0 : (count - CW'(pop) + CW'(push));
  assign space = (cnt_n < CW'(DEPTH));

  inst_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ('{pc: addr_q, instr: mem_rdata}),
    .pop       (pop),
    .flush     (redirect),
    .head      (head),
    .valid     (valid_out),
    .count     (count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      fetch_pc <= RESET_PC;
      addr_q   <= RESET_PC;
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
      addr_q   <= addr_n;
    end
  end

  // While in REQ, fetch_pc tracks the address in flight; in IDLE/DRAIN it
  // holds the next address to request.
  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    addr_n     = addr_q;
    case (state)
      S_IDLE: begin
        if (redirect) begin
          state_n    = S_REQ;
          fetch_pc_n = tgt;
          addr_n     = tgt;
        end else if (space) begin
          state_n = S_REQ;
          addr_n  = fetch_pc;
        end
      end
      S_REQ: begin
        if (xfer && redirect) begin
          fetch_pc_n = tgt;
          addr_n     = tgt;
        end else if (xfer) begin
          fetch_pc_n = addr_q + 32'd4;
          if (space) addr_n = addr_q + 32'd4;
          else       state_n = S_IDLE;
        end else if (redirect) begin
          // Address must stay stable until the pending ack arrives.
          state_n    = S_DRAIN;
          fetch_pc_n = tgt;
        end
      end
      S_DRAIN: begin
        if (xfer) begin
          state_n    = S_REQ;
          fetch_pc_n = redirect ? tgt : fetch_pc;
          addr_n     = redirect ? tgt : fetch_pc;
        end else if (redirect) begin
          fetch_pc_n = tgt;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign instr_out    = valid_out ? head.instr : '0;
  assign pc_out       = valid_out ? head.pc : '0;
  assign pc_plus4_out = valid_out ? (head.pc + 32'd4) : '0;

`ifdef PREFETCH_PERF_EN
  logic        drop;
  logic [32:0] disc_sum;

  assign drop     = xfer & (((state == S_REQ) & redirect) | (state == S_DRAIN));
  assign disc_sum = {1'b0, perf_discards} + 33'(drop) + (redirect ? 33'(count) : 33'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_empty_cycles <= '0;
      perf_discards     <= '0;
    end else begin
      if (!valid_out && (perf_empty_cycles != '1))
        perf_empty_cycles <= perf_empty_cycles + 32'd1;
      perf_discards <= disc_sum[32] ? '1 : disc_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Self-checking bench for inst_prefetch_queue. The reference model is the
// architectural instruction stream: after reset or a redirect to T, the
// consumed instructions must be T, T+4, T+8, ... with instr = pc ^ A5A5A5A5.
// Directed phases cover the timing corners; a randomized phase mixes
// stalls, redirects and memory latency.
module tb_inst_prefetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req, mem_ack, redirect = 1'b0, stall = 1'b0;
  logic [31:0] mem_addr, mem_rdata, redirect_pc = '0;
  logic        valid_out;
  logic [31:0] instr_out, pc_out, pc_plus4_out;
`ifdef PREFETCH_PERF_EN
  logic [31:0] perf_empty_cycles, perf_discards;
`endif

  int          vectors = 0;
  int          errors  = 0;
  int          ack_mode = 0;   // 0: ack tied 1, 1: random ack, 2: ack after 3 wait cycles
  int          wait_cnt = 0;
  logic        rnd_ack = 1'b0;
  logic [31:0] exp_q[$];

  logic        prev_req = 1'b0, prev_ack = 1'b0, prev_rst = 1'b1;
  logic [31:0] prev_addr = '0;

  inst_prefetch_queue dut (
    .clk          (clk),
    .rst          (rst),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .stall        (stall),
    .valid_out    (valid_out),
    .instr_out    (instr_out),
    .pc_out       (pc_out),
    .pc_plus4_out (pc_plus4_out)
`ifdef PREFETCH_PERF_EN
    ,
    .perf_empty_cycles (perf_empty_cycles),
    .perf_discards     (perf_discards)
`endif
  );

  always #5 clk = ~clk;

  // Memory model.
  assign mem_rdata = mem_addr ^ 32'hA5A5_A5A5;
  assign mem_ack   = (ack_mode == 0) ? 1'b1 :
                     (ack_mode == 1) ? rnd_ack :
                     (mem_req && (wait_cnt >= 3));

  always @(posedge clk) begin
    rnd_ack <= 1'($urandom_range(0, 1));
    if (rst)                  wait_cnt <= 0;
    else if (mem_req && mem_ack) wait_cnt <= 0;
    else if (mem_req)         wait_cnt <= wait_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Start a new expected stream at the given word address.
  task automatic restart(input logic [31:0] pc);
    exp_q.delete();
    for (int i = 0; i < 256; i++) exp_q.push_back(pc + 32'(4 * i));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_wait1(input string name);
    bit found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (mem_req && wait_cnt == 1) found = 1'b1;
      else step();
    end
    check(name, 32'(found), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   32'(mem_req),   32'd0);
    check({tag, "_addr"},  mem_addr,       32'h0);
    check({tag, "_valid"}, 32'(valid_out), 32'd0);
    check({tag, "_instr"}, instr_out,      32'h0);
    check({tag, "_pc"},    pc_out,         32'h0);
    check({tag, "_pc4"},   pc_plus4_out,   32'h0);
`ifdef PREFETCH_PERF_EN
    check({tag, "_perf_empty"}, perf_empty_cycles, 32'h0);
    check({tag, "_perf_disc"},  perf_discards,     32'h0);
`endif
  endtask

  // Monitor: compares every consumed instruction against the stream model
  // and checks output gating and request stability.
  always @(negedge clk) begin
    logic [31:0] e;
    if (!rst) begin
      if (valid_out && !stall && !redirect) begin
        if (exp_q.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL sb_underflow: got pc %h expected none", pc_out);
        end else begin
          e = exp_q.pop_front();
          check("sb_pc",    pc_out,       e);
          check("sb_instr", instr_out,    e ^ 32'hA5A5_A5A5);
          check("sb_pc4",   pc_plus4_out, e + 32'd4);
        end
      end
      if (!valid_out) begin
        check("gate_instr", instr_out,    32'h0);
        check("gate_pc",    pc_out,       32'h0);
        check("gate_pc4",   pc_plus4_out, 32'h0);
      end
      if (prev_req && !prev_ack && !prev_rst) begin
        check("req_hold",  32'(mem_req), 32'd1);
        check("addr_hold", mem_addr,     prev_addr);
      end
      if (mem_req) check("addr_align", 32'(mem_addr[1:0]), 32'd0);
    end
    prev_req  = mem_req;
    prev_ack  = mem_ack;
    prev_addr = mem_addr;
    prev_rst  = rst;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held;
    bit          found;
    int          since;

    // Reset and zero-wait streaming.
    restart(32'h0);
    repeat (2) step();
    rst = 1'b0;
    check_reset_outputs("rst");
    step();
    check("t1_req_c1",  32'(mem_req), 32'd1);
    check("t1_addr_c1", mem_addr,     32'h0);
    step();
    check("t1_valid_c2", 32'(valid_out), 32'd1);
    check("t1_pc_c2",    pc_out,         32'h0);
    check("t1_pc4_c2",   pc_plus4_out,   32'h4);
    repeat (8) step();

    // Stall until full, then release.
    stall = 1'b1;
    repeat (10) step();
    check("t2_req_full",   32'(mem_req),   32'd0);
    check("t2_valid_full", 32'(valid_out), 32'd1);
    stall = 1'b0;
    step();
    check("t2_rearm", 32'(mem_req), 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("t2_nobubble", 32'(valid_out), 32'd1);
      step();
    end

    // Redirect during a delayed ack: drained, then fetch at target.
    ack_mode = 2;
    wait_wait1("t3_wait1");
    held        = mem_addr;
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    restart(32'h100);
    step();
    redirect = 1'b0;
    check("t3_drain_req",  32'(mem_req), 32'd1);
    check("t3_drain_addr", mem_addr,     held);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (mem_req && mem_addr == 32'h100) found = 1'b1;
      else step();
    end
    check("t3_req_target", 32'(found), 32'd1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (valid_out) found = 1'b1;
      else step();
    end
    check("t3_valid_seen", 32'(found), 32'd1);
    check("t3_first_pc",   pc_out,     32'h100);

    // Redirect with full queue and same-cycle push/pop.
    ack_mode = 0;
    stall = 1'b1;
    repeat (10) step();
    stall = 1'b0;
    step();
    check("t4_req", 32'(mem_req), 32'd1);
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    restart(32'h200);
    step();
    redirect = 1'b0;
    check("t4_empty", 32'(valid_out), 32'd0);
    check("t4_req1",  32'(mem_req),   32'd1);
    check("t4_addr1", mem_addr,       32'h200);
    step();
    check("t4_valid2", 32'(valid_out), 32'd1);
    check("t4_pc2",    pc_out,         32'h200);
    repeat (3) step();

    // Redirect near the top of the address space (unaligned target).
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    restart(32'hFFFF_FFFC);
    step();
    redirect = 1'b0;
    step();
    check("t5_pc_top",  pc_out,       32'hFFFF_FFFC);
    check("t5_pc4_top", pc_plus4_out, 32'h0);
    step();
    check("t5_pc_wrap", pc_out, 32'h0);
    repeat (3) step();

    // Reset while draining.
    ack_mode = 2;
    wait_wait1("t6_wait1");
    redirect    = 1'b1;
    redirect_pc = 32'h300;
    restart(32'h300);
    step();
    redirect = 1'b0;
    check("t6_drain_req", 32'(mem_req), 32'd1);
    rst = 1'b1;
    restart(32'h0);
    step();
    check_reset_outputs("t6_rst");
    rst = 1'b0;
    step();
    check("t6_restart_req",  32'(mem_req), 32'd1);
    check("t6_restart_addr", mem_addr,     32'h0);
    repeat (10) step();

    // Randomized stalls, redirects and memory latency.
    since = 0;
    for (int blk = 0; blk < 3; blk++) begin
      ack_mode = (blk == 0) ? 1 : ((blk == 1) ? 2 : 0);
      for (int i = 0; i < 600; i++) begin
        stall = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 24) == 0 || since >= 200) begin
          redirect_pc = $urandom;
          redirect    = 1'b1;
          restart(redirect_pc & 32'hFFFF_FFFC);
          since = 0;
        end else begin
          redirect = 1'b0;
          since++;
        end
        step();
      end
    end
    redirect = 1'b0;
    stall    = 1'b0;
    repeat (20) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
